// File: rtl/clk_sel_pkg.sv
// Shared types and constants for the clock-select control path.
package clk_sel_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ASSERT,
    ST_WAIT_RELEASE
  } state_e;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/reset_level_sync.sv
// Multi-flop level synchronizer for a 1-bit status signal; resets to 0.
module reset_level_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_select_ctrl.sv
// Issues SELECT/SELECT_ENABLE to the two-clock selector and acknowledges once
// the newly selected domain has been seen leaving reset.
module clock_select_ctrl
  import clk_sel_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ASSERT_WAIT = 8,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 11
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
  output logic REQ_READY,
  output logic SELECT,
  output logic SELECT_ENABLE,
  input  logic SEL_RST_N,
  output logic CUR_SEL,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  localparam logic [CNT_W-1:0] AW_LAST = CNT_W'(ASSERT_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             select_q, select_d;
  logic             cur_sel_q, cur_sel_d;
  logic             sel_en_q, sel_en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rst_n_s;

  reset_level_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (SEL_RST_N),
    .q_o  (rst_n_s)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    select_d  = select_q;
    cur_sel_d = cur_sel_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (rst_n_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_IDLE: begin
        if (REQ_VALID) begin
          if (REQ_SEL == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            select_d = REQ_SEL;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cur_sel_d = select_q;
        cnt_d     = '0;
        state_d   = ST_WAIT_ASSERT;
      end
      // A fast new clock may finish its reset before the synchronizer sees it,
      // so expiring here just moves on to the release wait.
      ST_WAIT_ASSERT: begin
        if (!rst_n_s || cnt_q == AW_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_RELEASE: begin
        if (rst_n_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_INIT;
    endcase
    sel_en_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      select_q  <= SEL_B;
      cur_sel_q <= SEL_B;
      sel_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      select_q  <= select_d;
      cur_sel_q <= cur_sel_d;
      sel_en_q  <= sel_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign REQ_READY     = (state_q == ST_IDLE);
  assign BUSY          = (state_q != ST_IDLE);
  assign SELECT        = select_q;
  assign SELECT_ENABLE = sel_en_q;
  assign CUR_SEL       = cur_sel_q;
  assign DONE          = done_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_clock_select_ctrl.sv
// Scoreboard bench for clock_select_ctrl with a simple selector reset model.
module tb_clock_select_ctrl;

  localparam int SYNC    = 2;
  localparam int AWAIT   = 8;
  localparam int TOUT    = 1024;
  localparam int PERIOD  = 10;
  localparam int HALF    = 5;
  localparam int HOLD    = 2;
  localparam int LOW     = 6;
  localparam int M_NONE  = 0;
  localparam int M_PULSE = 1;
  localparam int M_FOREV = 2;

  typedef struct {
    int lat;
    int err;
    int cur;
  } exp_t;

  logic CLK, RST, REQ_VALID, REQ_SEL, REQ_READY, SELECT, SELECT_ENABLE;
  logic SEL_RST_N, CUR_SEL, BUSY, DONE, ERR;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   sel_en_cnt = 0;
  int   en_before = 0;
  int   exp_pulses = 0;
  logic exp_select = 1'b0;
  logic cur_model = 1'b0;
  time  t_acc = 0;

  clock_select_ctrl #(
    .SYNC_STAGES(SYNC),
    .ASSERT_WAIT(AWAIT),
    .TIMEOUT    (TOUT),
    .CNT_W      (11)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_VALID    (REQ_VALID),
    .REQ_SEL      (REQ_SEL),
    .REQ_READY    (REQ_READY),
    .SELECT       (SELECT),
    .SELECT_ENABLE(SELECT_ENABLE),
    .SEL_RST_N    (SEL_RST_N),
    .CUR_SEL      (CUR_SEL),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERR          (ERR)
  );

  initial CLK = 1'b0;
  always #HALF CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every DONE pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (SELECT_ENABLE) begin
        sel_en_cnt++;
        check_eq("select_at_enable", SELECT, exp_select);
      end
      if (ERR && !DONE) check_eq("err_without_done", DONE, 1);
      if (DONE) begin
        if (sb.size() == 0) begin
          check_eq("spurious_done", DONE, 0);
        end else begin
          e = sb.pop_front();
          check_eq("done_latency", 32'(($time - t_acc + HALF) / PERIOD), e.lat);
          check_eq("err_at_done", ERR, e.err);
          check_eq("cur_sel_at_done", CUR_SEL, e.cur);
        end
      end
    end
  end

  task automatic start_req(input logic sel, input int mode);
    exp_t e;
    logic differ;
    differ = (sel != cur_model);
    e.cur  = sel;
    e.err  = (differ && mode == M_FOREV) ? 1 : 0;
    if (!differ)              e.lat = 1;
    else if (mode == M_NONE)  e.lat = AWAIT + 3;
    else if (mode == M_PULSE) e.lat = HOLD + LOW + SYNC + 2;
    else                      e.lat = HOLD + SYNC + TOUT + 2;
    sb.push_back(e);
    cur_model  = sel;
    exp_pulses = differ ? 1 : 0;
    en_before  = sel_en_cnt;
    if (differ) exp_select = sel;
    REQ_VALID = 1'b1;
    REQ_SEL   = sel;
    check_eq("ready_at_req", REQ_READY, 1);
    @(posedge CLK);
    t_acc = $time;
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    check_eq("busy_after_accept", BUSY, differ);
    if (differ && mode != M_NONE) begin
      repeat (HOLD) @(posedge CLK);
      #1 SEL_RST_N = 1'b0;
      if (mode == M_PULSE) begin
        repeat (LOW) @(posedge CLK);
        #1 SEL_RST_N = 1'b1;
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge CLK);
    #1;
    check_eq("done_seen", sb.size(), 0);
    sb.delete();
    check_eq("sel_en_pulses", sel_en_cnt - en_before, exp_pulses);
  endtask

  initial begin
    RST = 1'b1;
    REQ_VALID = 1'b0;
    REQ_SEL = 1'b0;
    SEL_RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_ready", REQ_READY, 0);
    check_eq("rst_busy", BUSY, 1);
    check_eq("rst_select", SELECT, 0);
    check_eq("rst_sel_en", SELECT_ENABLE, 0);
    check_eq("rst_cur_sel", CUR_SEL, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_err", ERR, 0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("init_not_ready", REQ_READY, 0);
    @(posedge CLK);
    @(negedge CLK);
    check_eq("init_exit_ready", REQ_READY, 1);
    check_eq("init_exit_busy", BUSY, 0);
    check_eq("init_exit_cur", CUR_SEL, 0);
    @(posedge CLK);
    #1;

    start_req(1'b0, M_NONE);  wait_done();
    start_req(1'b1, M_PULSE); wait_done();
    start_req(1'b0, M_NONE);  wait_done();
    start_req(1'b1, M_FOREV); wait_done();

    // Selector reset still low while idle must be ignored.
    repeat (4) @(posedge CLK);
    #1;
    check_eq("idle_ready_rst_low", REQ_READY, 1);
    check_eq("idle_busy_rst_low", BUSY, 0);
    SEL_RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    start_req(1'b1, M_NONE);  wait_done();
    start_req(1'b0, M_NONE);  wait_done();

    // Reset asserted mid-way through the release wait.
    start_req(1'b1, M_FOREV);
    repeat (6) @(posedge CLK);
    #2;
    check_eq("pre_rst_select", SELECT, 1);
    check_eq("pre_rst_busy", BUSY, 1);
    RST = 1'b1;
    #1;
    check_eq("mid_rst_select", SELECT, 0);
    check_eq("mid_rst_sel_en", SELECT_ENABLE, 0);
    check_eq("mid_rst_cur", CUR_SEL, 0);
    check_eq("mid_rst_busy", BUSY, 1);
    check_eq("mid_rst_ready", REQ_READY, 0);
    check_eq("mid_rst_done", DONE, 0);
    check_eq("mid_rst_err", ERR, 0);
    sb.delete();
    cur_model = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check_eq("init_hold_ready", REQ_READY, 0);
    check_eq("init_hold_busy", BUSY, 1);
    SEL_RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reinit_ready", REQ_READY, 1);
    start_req(1'b0, M_NONE);  wait_done();

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
